// File: rtl/best_move_scan.sv
// ============================================================================
//  Module      : best_move_scan
//  Description : Sequences an external evaluator over a list of moves and
//                keeps the best (max or min) signed evaluation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module best_move_scan #(
    parameter int EVAL_WIDTH  = 24,
    parameter int INDEX_WIDTH = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [INDEX_WIDTH-1:0]        move_count,
    input  logic                          maximize,
    output logic [INDEX_WIDTH-1:0]        move_index,
    output logic                          clear_eval,
    input  logic                          eval_valid,
    input  logic signed [EVAL_WIDTH-1:0]  eval,
    output logic                          busy,
    output logic                          done,
    output logic [INDEX_WIDTH-1:0]        best_index,
    output logic signed [EVAL_WIDTH-1:0]  best_eval,
    output logic                          timeout_err
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_clear = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic signed [EVAL_WIDTH-1:0] c_eval_min = {1'b1, {(EVAL_WIDTH-1){1'b0}}};
    localparam logic signed [EVAL_WIDTH-1:0] c_eval_max = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
    localparam logic [15:0]                  c_timeout  = 16'(TIMEOUT);

    logic [1:0]                    r_state;
    logic [INDEX_WIDTH-1:0]        r_idx;
    logic [INDEX_WIDTH-1:0]        r_count;
    logic                          r_max;
    logic [15:0]                   r_wait_cnt;
    logic                          r_clear;
    logic                          r_busy;
    logic                          r_done;
    logic [INDEX_WIDTH-1:0]        r_best_idx;
    logic signed [EVAL_WIDTH-1:0]  r_best_eval;
    logic                          r_timeout;

    logic w_better;
    logic w_last;
    logic w_expire;

    // Move 0 always wins so the seed never survives a completed scan.
    assign w_better = (r_idx == '0) ||
                      (r_max ? (eval > r_best_eval) : (eval < r_best_eval));
    assign w_last   = (r_idx == r_count - INDEX_WIDTH'(1));
    assign w_expire = ((r_wait_cnt + 16'd1) == c_timeout);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_idle;
            r_idx       <= '0;
            r_count     <= '0;
            r_max       <= 1'b0;
            r_wait_cnt  <= '0;
            r_clear     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_best_idx  <= '0;
            r_best_eval <= '0;
            r_timeout   <= 1'b0;
        end else if (abort && (r_state != c_idle)) begin
            r_state <= c_idle;
            r_clear <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_clear <= 1'b0;
                    r_done  <= 1'b0;
                    if (start) begin
                        r_idx       <= '0;
                        r_count     <= move_count;
                        r_max       <= maximize;
                        r_timeout   <= 1'b0;
                        r_best_idx  <= '0;
                        r_best_eval <= maximize ? c_eval_min : c_eval_max;
                        r_busy      <= 1'b1;
                        r_wait_cnt  <= '0;
                        if (move_count != '0) begin
                            r_state <= c_clear;
                            r_clear <= 1'b1;
                        end else begin
                            r_state <= c_done;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_clear: begin
                    r_clear <= 1'b0;
                    r_state <= c_wait;
                end
                c_wait: begin
                    if (eval_valid) begin
                        if (w_better) begin
                            r_best_idx  <= r_idx;
                            r_best_eval <= eval;
                        end
                        if (w_last) begin
                            r_state <= c_done;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx      <= r_idx + INDEX_WIDTH'(1);
                            r_wait_cnt <= '0;
                            r_state    <= c_clear;
                            r_clear    <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                        if (w_expire) begin
                            r_timeout <= 1'b1;
                            r_state   <= c_done;
                            r_done    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign move_index  = r_idx;
    assign clear_eval  = r_clear;
    assign busy        = r_busy;
    assign done        = r_done;
    assign best_index  = r_best_idx;
    assign best_eval   = r_best_eval;
    assign timeout_err = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_best_move_scan.sv
// ============================================================================
//  Module      : tb_best_move_scan
//  Description : Directed self-checking bench for best_move_scan.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_best_move_scan;

    localparam int EW = 24;
    localparam int IW = 8;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [IW-1:0]        move_count;
    logic                 maximize;
    logic [IW-1:0]        move_index;
    logic                 clear_eval;
    logic                 eval_valid;
    logic signed [EW-1:0] eval;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        best_index;
    logic signed [EW-1:0] best_eval;
    logic                 timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [EW-1:0] ev_val [8];
    int                   ev_dly [8];

    best_move_scan #(
        .EVAL_WIDTH (EW),
        .INDEX_WIDTH(IW),
        .TIMEOUT    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .move_count (move_count),
        .maximize   (maximize),
        .move_index (move_index),
        .clear_eval (clear_eval),
        .eval_valid (eval_valid),
        .eval       (eval),
        .busy       (busy),
        .done       (done),
        .best_index (best_index),
        .best_eval  (best_eval),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Evaluator model: answers move m after ev_dly[m] WAIT cycles (0 = never).
    // done_k counts negedges from the start-driving negedge to the done pulse.
    task automatic run_scan(input int cnt, input bit mx, input int ab_move, input int ab_w,
                            input int xs_k, output int done_k, output int clears);
        int  cur;
        int  wcnt;
        bit  in_wait;
        bit  ab_sent;
        bit  finished;
        done_k   = -1;
        clears   = 0;
        cur      = 0;
        wcnt     = 0;
        in_wait  = 0;
        ab_sent  = 0;
        finished = 0;
        @(negedge clk);
        start      = 1'b1;
        move_count = IW'(cnt);
        maximize   = mx;
        for (int k = 1; k <= 300 && !finished; k++) begin
            @(negedge clk);
            start      = 1'b0;
            eval_valid = 1'b0;
            abort      = 1'b0;
            if (ab_sent) begin
                check_value("abort_busy", busy, 0);
                check_value("abort_done", done, 0);
                check_value("abort_clear", clear_eval, 0);
                finished = 1;
            end else begin
                if (k == xs_k) begin
                    start      = 1'b1;
                    move_count = IW'(1);
                    maximize   = !mx;
                end
                if (clear_eval) begin
                    check_value("clear_index", move_index, clears);
                    cur     = clears;
                    clears++;
                    wcnt    = 0;
                    in_wait = 1;
                end else if (done) begin
                    done_k   = k;
                    finished = 1;
                end else if (in_wait) begin
                    wcnt++;
                    if (cur == ab_move && wcnt == ab_w) begin
                        abort   = 1'b1;
                        ab_sent = 1;
                    end else if (ev_dly[cur] == wcnt) begin
                        eval_valid = 1'b1;
                        eval       = ev_val[cur];
                    end
                end
            end
        end
        if (!finished) check_value("scan_finished", finished, 1);
        start = 1'b0;
    endtask

    initial begin
        int dk;
        int nc;
        bit saw_done;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        move_count = '0;
        maximize   = 1'b0;
        eval_valid = 1'b0;
        eval       = '0;
        repeat (3) @(negedge clk);
        check_value("rst_move_index", move_index, 0);
        check_value("rst_clear_eval", clear_eval, 0);
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_best_index", best_index, 0);
        check_value("rst_best_eval", best_eval, 0);
        check_value("rst_timeout", timeout_err, 0);
        reset = 1'b0;

        // Maximize 5, -2, 9 with immediate answers
        ev_val[0] = 5;  ev_val[1] = -2; ev_val[2] = 9;
        ev_dly[0] = 1;  ev_dly[1] = 1;  ev_dly[2] = 1;
        run_scan(3, 1'b1, -1, 0, 0, dk, nc);
        check_value("max_clears", nc, 3);
        check_value("max_done_cycle", dk, 7);
        check_value("max_busy_in_done", busy, 1);
        check_value("max_best_index", best_index, 2);
        check_value("max_best_eval", best_eval, 9);
        check_value("max_timeout", timeout_err, 0);
        @(negedge clk);
        check_value("max_done_pulse", done, 0);
        check_value("max_busy_after", busy, 0);

        // Minimize with ties and mixed latencies
        ev_val[0] = 3;  ev_val[1] = 3;  ev_val[2] = -7; ev_val[3] = -7;
        ev_dly[0] = 2;  ev_dly[1] = 1;  ev_dly[2] = 3;  ev_dly[3] = 1;
        run_scan(4, 1'b0, -1, 0, 0, dk, nc);
        check_value("min_clears", nc, 4);
        check_value("min_done_cycle", dk, 12);
        check_value("min_best_index", best_index, 2);
        check_value("min_best_eval", best_eval, -7);

        // Empty move list
        run_scan(0, 1'b1, -1, 0, 0, dk, nc);
        check_value("zero_clears", nc, 0);
        check_value("zero_done_cycle", dk, 1);
        check_value("zero_best_index", best_index, 0);
        check_value("zero_best_eval", best_eval, -8388608);
        check_value("zero_timeout", timeout_err, 0);

        // Timeout on move 1
        ev_val[0] = 10; ev_dly[0] = 1; ev_dly[1] = 0;
        run_scan(2, 1'b1, -1, 0, 0, dk, nc);
        check_value("to_done_cycle", dk, 8);
        check_value("to_timeout", timeout_err, 1);
        check_value("to_best_index", best_index, 0);
        check_value("to_best_eval", best_eval, 10);

        // Next accepted start clears the timeout flag
        ev_val[0] = -100; ev_dly[0] = 2;
        run_scan(1, 1'b0, -1, 0, 0, dk, nc);
        check_value("after_to_done_cycle", dk, 4);
        check_value("after_to_timeout", timeout_err, 0);
        check_value("after_to_best_eval", best_eval, -100);

        // Abort in WAIT of move 1, then a normal scan
        ev_val[0] = 1; ev_val[1] = 2; ev_val[2] = 3;
        ev_dly[0] = 1; ev_dly[1] = 3; ev_dly[2] = 1;
        run_scan(3, 1'b1, 1, 1, 0, dk, nc);
        check_value("abort_no_done", dk, -1);
        check_value("abort_best_index", best_index, 0);
        check_value("abort_best_eval", best_eval, 1);
        saw_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check_value("abort_quiet", saw_done, 0);
        ev_val[0] = 4; ev_val[1] = 7;
        ev_dly[0] = 1; ev_dly[1] = 1;
        run_scan(2, 1'b1, -1, 0, 0, dk, nc);
        check_value("post_abort_done_cycle", dk, 5);
        check_value("post_abort_best_index", best_index, 1);
        check_value("post_abort_best_eval", best_eval, 7);

        // Extra start while busy must be ignored
        ev_val[0] = 5;  ev_val[1] = -2; ev_val[2] = 9;
        ev_dly[0] = 1;  ev_dly[1] = 1;  ev_dly[2] = 1;
        run_scan(3, 1'b1, -1, 0, 2, dk, nc);
        check_value("xs_done_cycle", dk, 7);
        check_value("xs_clears", nc, 3);
        check_value("xs_best_index", best_index, 2);
        check_value("xs_best_eval", best_eval, 9);

        // Reset mid-scan
        @(negedge clk);
        start = 1'b1; move_count = IW'(3); maximize = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_value("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_value("mrst_move_index", move_index, 0);
        check_value("mrst_clear_eval", clear_eval, 0);
        check_value("mrst_busy", busy, 0);
        check_value("mrst_best_index", best_index, 0);
        check_value("mrst_best_eval", best_eval, 0);
        check_value("mrst_timeout", timeout_err, 0);
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        check_value("mrst_quiet", saw_done, 0);

        // Reset outranks a simultaneous start
        start = 1'b1; reset = 1'b1; move_count = IW'(2);
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        check_value("rst_over_start_busy", busy, 0);
        check_value("rst_over_start_clear", clear_eval, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
